demux_1x2_32_reg: RTL

//  Registered 1-to-2 demultiplexer for 32-bit datapath words, the splitting counterpart of the
//  2-to-1 word mux. Steers one valid/ready input stream to one of two output channels selected
//  per word by s, with a one-entry holding register per channel.

---
 rtl/demux_1x2_32_reg.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/demux_1x2_32_reg.sv
// ---------------------------------------------------------------------------
// demux_1x2_32_reg
//
// Registered 1-to-2 demultiplexer for datapath words. Each input word is
// steered by s to one of two output channels. Each channel has a one-entry
// holding register, so a stalled consumer only blocks words meant for it.
//
// Optional feature macro: DEMUX_STATS_EN
//   When defined, count0/count1 report the number of words accepted for
//   each channel. The counters wrap and are cleared by rst.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   in          in   input word
//   in_valid    in   input word present
//   s           in   channel select (0 -> out0, 1 -> out1)
//   in_ready    out  word accepted this cycle when in_valid && in_ready
//   out0        out  channel 0 holding register
//   out0_valid  out  channel 0 holds a word
//   out0_ready  in   channel 0 consumer takes the word
//   out1        out  channel 1 holding register
//   out1_valid  out  channel 1 holds a word
//   out1_ready  in   channel 1 consumer takes the word
//   count0      out  words accepted for channel 0 (DEMUX_STATS_EN only)
//   count1      out  words accepted for channel 1 (DEMUX_STATS_EN only)
// ---------------------------------------------------------------------------
module demux_1x2_32_reg #(
  parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             s,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] count0,
  output logic [CNT_WIDTH-1:0] count1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chState_e;

  chState_e         state0_q, state0_d;
  chState_e         state1_q, state1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic             accept0;
  logic             accept1;

  // A channel can take a new word when it is empty or is being drained in
  // this same cycle. Only the selected channel gates the input.
  assign in_ready = s ? ((state1_q == EMPTY) || out1_ready)
                      : ((state0_q == EMPTY) || out0_ready);

  assign accept0 = in_valid && in_ready && !s;
  assign accept1 = in_valid && in_ready &&  s;

  // Next-state for both channel FSMs. A drained channel keeps its last
  // data value; a load while draining gives back-to-back transfers.
  always_comb begin
    state0_d = state0_q;
    data0_d  = data0_q;
    state1_d = state1_q;
    data1_d  = data1_q;

    case (state0_q)
      EMPTY: begin
        if (accept0) begin
          state0_d = FULL;
          data0_d  = in;
        end
      end
      FULL: begin
        if (accept0) begin
          data0_d = in;
        end else if (out0_ready) begin
          state0_d = EMPTY;
        end
      end
      default: state0_d = EMPTY;
    endcase

    case (state1_q)
      EMPTY: begin
        if (accept1) begin
          state1_d = FULL;
          data1_d  = in;
        end
      end
      FULL: begin
        if (accept1) begin
          data1_d = in;
        end else if (out1_ready) begin
          state1_d = EMPTY;
        end
      end
      default: state1_d = EMPTY;
    endcase
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state0_q <= EMPTY;
      state1_q <= EMPTY;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

  assign out0       = data0_q;
  assign out1       = data1_q;
  assign out0_valid = (state0_q == FULL);
  assign out1_valid = (state1_q == FULL);

`ifdef DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] count0_q, count1_q;

  // Per-channel accept counters, wrapping naturally at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      if (accept0) count0_q <= count0_q + CNT_WIDTH'(1);
      if (accept1) count1_q <= count1_q + CNT_WIDTH'(1);
    end
  end

  assign count0 = count0_q;
  assign count1 = count1_q;
`endif

endmodule
